// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator with two line buffers and per-channel window registers
module conv_window_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int CH     = 3,
    parameter int ACT_W  = 8,
    parameter int STRIDE = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [CH*ACT_W-1:0]       in_pix,
    output logic                      window_valid,
    output logic [CH*9*ACT_W-1:0]     window_act,
    output logic                      frame_done
);
    localparam int PW = CH * ACT_W;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]     x, px;
    logic [YW-1:0]     y, py;
    logic [PW-1:0]     lb1 [IMG_W];
    logic [PW-1:0]     lb2 [IMG_W];
    logic [PW-1:0]     row1, row2;
    logic [3*PW-1:0]   col;
    logic [9*PW-1:0]   win, win_nxt;
    logic              emit, last;

    // A start-of-frame pixel is always treated as (0,0), which resyncs a stream mid-frame
    assign px   = in_sof ? '0 : x;
    assign py   = in_sof ? '0 : y;
    assign row1 = lb1[px];
    assign row2 = lb2[px];
    // Incoming column, top (oldest row) in the low slice
    assign col  = {in_pix, row1, row2};
    // With stride 2 the (pos-2)%2==0 test reduces to the position being even
    assign emit = in_valid && px >= XW'(2) && py >= YW'(2) && (STRIDE == 1 || (!px[0] && !py[0]));
    assign last = px == X_LAST && py == Y_LAST;

    // Next window: each row shifts left by one tap and takes the new column value on the right
    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar k = 0; k < 3; k++) begin : g_row
            localparam int B = ACT_W * (9 * c + 3 * k);
            assign win_nxt[B +: 2*ACT_W]       = win[B + ACT_W +: 2*ACT_W];
            assign win_nxt[B + 2*ACT_W +: ACT_W] = col[PW*k + ACT_W*c +: ACT_W];
        end
    end

    // Line buffers and window registers; contents are always rewritten before they are used
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[px] <= in_pix;
            lb2[px] <= row1;
            win     <= win_nxt;
        end
    end

    // Position counters and registered outputs, one cycle behind the accepted pixel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x            <= '0;
            y            <= '0;
            window_valid <= 1'b0;
            window_act   <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= emit;
            frame_done   <= in_valid && last;
            if (emit)
                window_act <= win_nxt;
            if (in_valid) begin
                x <= px == X_LAST ? '0 : px + 1'b1;
                y <= px == X_LAST ? (py == Y_LAST ? '0 : py + 1'b1) : py;
            end
        end
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 sliding-window generator. It is the transmitter that feeds the fully-unrolled conv layers' `valid`/`input_act` interface.
- Accepts one multi-channel pixel per cycle in raster order.
- Buffers two image rows in line buffers plus a 3x3 register window per channel.
- Emits one packed window word, with a valid pulse, per output position of an unpadded ("valid") 3x3 convolution with configurable stride.

Parameters:
- IMG_W, 32, image width in pixels (>=3)
- IMG_H, 32, image height in pixels (>=3)
- CH, 3, channels per pixel
- ACT_W, 8, bits per activation
- STRIDE, 1, window stride in x and y; legal values 1 or 2

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  pixel strobe; gaps allowed, no backpressure
- in_sof  input  1  start-of-frame; qualified by in_valid, marks pixel (0,0)
- in_pix  input  CH*ACT_W  pixel; channel c at [ACT_W*c +: ACT_W]
- window_valid  output  1  window strobe; drives conv `valid`
- window_act  output  CH*9*ACT_W  packed window; drives conv `input_act`
- frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Interface: clock clk; reset rstn, asynchronous, active-low.
- Reset values: window_valid=0, window_act=0, frame_done=0, x=0, y=0.
  - Line-buffer and window-register contents are not reset; they are always rewritten before use.
- Position counters x in [0,IMG_W-1] and y in [0,IMG_H-1] give the coordinates of the current accepted pixel.
  - They advance only when in_valid=1.
  - x wraps to 0 at IMG_W-1 and increments y.
  - At (IMG_W-1,IMG_H-1) both wrap to 0.
- in_sof=1 with in_valid=1: the pixel is taken as (0,0) regardless of counter state, so the generator resyncs mid-frame.
  - Any partial frame is abandoned and no frame_done is issued for it.
  - in_sof without in_valid is ignored.
- Line buffers: two IMG_W-deep buffers, each CH*ACT_W wide, addressed by x.
  - On each accepted pixel, read both entries at x to get rows y-2 and y-1.
  - Write row-1 data into the row-2 buffer and in_pix into the row-1 buffer, same cycle.
  - Read-before-write semantics.
- Window registers: for each channel, a 3x3 shift register.
  - On each accepted pixel, columns shift left.
  - The new right column gets {row y-2, row y-1, row y} at column x.
- Emission condition on an accepted pixel at (x,y):
  - x>=2 and y>=2, and
  - (x-2)%STRIDE==0 and (y-2)%STRIDE==0.
- Latency: exactly 1 cycle after the accepted pixel.
  - window_valid=1 and window_act hold the window spanning rows y-2..y and columns x-2..x.
  - window_valid is a single-cycle pulse.
  - window_act holds its value until the next emission.
- Packing: window_act[72c' + 8(3*ky+kx) +: 8], generalised to window_act[ACT_W*(9c+3ky+kx) +: ACT_W].
  - Holds pixel(x-2+kx, y-2+ky) channel c.
  - ky=0 is the oldest (top) row; kx=0 is the leftmost column.
- Windows per frame: floor((IMG_W-3)/STRIDE+1) * floor((IMG_H-3)/STRIDE+1).
- frame_done: pulses 1 cycle after pixel (IMG_W-1,IMG_H-1) is accepted. If that pixel also emits a window, frame_done is coincident with window_valid.
- Back-to-back frames with no idle cycle are supported; the first pixel of the next frame may arrive on the cycle frame_done is high.
- Reset mid-frame: counters return to 0 and pending window_valid/frame_done are dropped. The next accepted pixel is (0,0).
- No window is ever emitted using data from a previous frame.

Test Plan:
- IMG_W=4, IMG_H=4, STRIDE=1, CH=1, ch0 pixel=4y+x, continuous stream:
  - 4 windows, first on the cycle after pixel 10, with taps k0..k8 = 0,1,2,4,5,6,8,9,10.
  - Last window taps = 5,6,7,9,10,11,13,14,15.
  - frame_done coincides with the last window.
- Same stimulus with random in_valid gaps (30% idle) -> identical window sequence and values; each window_valid exactly 1 cycle after its triggering accepted pixel.
- IMG_W=6, IMG_H=6, STRIDE=2 -> exactly 4 windows, centred-left at (2,2),(4,2),(2,4),(4,4); x=3/5 and y=3/5 pixels emit nothing.
- CH=3, channel c value = 4y+x+64c -> channel c slice of each window equals the ch0 window +64c per tap; channel slices land at bits [72c+71:72c].
- Two back-to-back frames, second frame pixel values +100, then in_sof asserted at pixel (1,2) of a third frame:
  - Second frame windows contain no first-frame data.
  - The resync restarts counting with no window until new (2,2).
  - No frame_done for the aborted frame.
- rstn pulsed low mid-frame right after a triggering pixel -> window_valid and frame_done stay 0; after release, a full 4x4 frame yields the 4 correct windows.
